// File: rtl/sb_data_decoder.sv
// sb_data_decoder: decodes deframed sideband messages into a held payload with ready/overflow handshake.
module sb_data_decoder (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_msg_valid,
   input  logic        i_has_data,
   input  logic [3:0]  i_state,
   input  logic [3:0]  i_sub_state,
   input  logic [3:0]  i_msg_no,
   input  logic [63:0] i_data_field,
   input  logic        i_tx_point_sweep_test_en,
   input  logic [1:0]  i_tx_point_sweep_test,
   input  logic        i_rdy,
   output logic        o_msg_valid,
   output logic [3:0]  o_msg_no,
   output logic        o_data_valid,
   output logic [15:0] o_data_bus,
   output logic        o_fmt_err,
   output logic        o_overflow
);
   typedef enum logic {IDLE, HOLD} state_t;
   localparam logic [3:0]  MBINIT     = 4'd3;
   localparam logic [3:0]  PARAM      = 4'd0;
   localparam logic [3:0]  REVERSALMB = 4'd4;
   // bits the point-test encoder may legitimately set: payload bits plus the 16-bit ones marker
   localparam logic [63:0] PT_MASK    = 64'h0FFF_F800_0000_08C1;
   state_t      state_q;
   logic        msg_valid_q, data_valid_q, fmt_err_q, overflow_q;
   logic [3:0]  msg_no_q;
   logic [15:0] data_bus_q;
   logic        data_valid_d, fmt_err_d;
   logic [15:0] data_bus_d;
   logic        accept, load, release_msg, drop, test_mode, pass16;
   logic [63:0] d;
   assign d           = i_data_field;
   assign accept      = i_msg_valid && i_msg_no != 4'd0;
   assign load        = accept && (state_q == IDLE || i_rdy);
   assign release_msg = state_q == HOLD && i_rdy && !accept;
   assign drop        = state_q == HOLD && !i_rdy && accept;
   assign test_mode   = i_tx_point_sweep_test_en && i_has_data;
   assign pass16      = (i_msg_no == 4'd6 && (i_tx_point_sweep_test == 2'd0 || i_tx_point_sweep_test == 2'd2)) ||
                        (i_msg_no == 4'd9 && i_tx_point_sweep_test == 2'd3);
   always_comb begin
      data_valid_d = 1'b0;
      data_bus_d   = 16'h0;
      fmt_err_d    = 1'b0;
      if (test_mode) begin
         if (i_msg_no == 4'd1) begin
            data_valid_d = 1'b1;
            data_bus_d   = {11'b0, d[59], d[11], d[7:6], d[0]};
            fmt_err_d    = d[58:43] != 16'hFFFF || (d & ~PT_MASK) != 64'h0;
         end else if (pass16) begin
            data_valid_d = 1'b1;
            data_bus_d   = d[15:0];
            fmt_err_d    = d[63:16] != 48'h0;
         end else begin
            fmt_err_d    = d != 64'h0;
         end
      end else if (i_has_data && i_state == MBINIT && i_sub_state == PARAM) begin
         data_valid_d = 1'b1;
         data_bus_d   = {5'b0, d[10:0]};
         fmt_err_d    = d[63:11] != 53'h0;
      end else if (i_has_data && i_state == MBINIT && i_sub_state == REVERSALMB && i_msg_no == 4'd6) begin
         data_valid_d = 1'b1;
         data_bus_d   = d[15:0];
         fmt_err_d    = d[63:16] != 48'h0;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         msg_valid_q  <= 1'b0;
         msg_no_q     <= 4'd0;
         data_valid_q <= 1'b0;
         data_bus_q   <= 16'h0;
         fmt_err_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (load) begin
            state_q      <= HOLD;
            msg_valid_q  <= 1'b1;
            msg_no_q     <= i_msg_no;
            data_valid_q <= data_valid_d;
            data_bus_q   <= data_bus_d;
            fmt_err_q    <= fmt_err_d;
         end else if (release_msg) begin
            state_q      <= IDLE;
            msg_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            fmt_err_q    <= 1'b0;
         end
         if (drop) overflow_q <= 1'b1;
      end
   end
   assign o_msg_valid  = msg_valid_q;
   assign o_msg_no     = msg_no_q;
   assign o_data_valid = data_valid_q;
   assign o_data_bus   = data_bus_q;
   assign o_fmt_err    = fmt_err_q;
   assign o_overflow   = overflow_q;
endmodule

// File: tb/tb_sb_data_decoder.sv
// tb_sb_data_decoder: directed vector table plus handshake/reset sequences for sb_data_decoder.
module tb_sb_data_decoder;
   logic        clk = 1'b0, rst = 1'b1;
   logic        msg_valid = 1'b0, has_data = 1'b0, en = 1'b0, rdy = 1'b0;
   logic [3:0]  st = 4'd0, sub = 4'd0, msg = 4'd0;
   logic [1:0]  typ = 2'd0;
   logic [63:0] d = 64'h0;
   logic        o_msg_valid, o_data_valid, o_fmt_err, o_overflow;
   logic [3:0]  o_msg_no;
   logic [15:0] o_data_bus;
   int checks = 0, failures = 0;

   sb_data_decoder dut (
      .i_clk(clk), .i_rst(rst), .i_msg_valid(msg_valid), .i_has_data(has_data),
      .i_state(st), .i_sub_state(sub), .i_msg_no(msg), .i_data_field(d),
      .i_tx_point_sweep_test_en(en), .i_tx_point_sweep_test(typ), .i_rdy(rdy),
      .o_msg_valid(o_msg_valid), .o_msg_no(o_msg_no), .o_data_valid(o_data_valid),
      .o_data_bus(o_data_bus), .o_fmt_err(o_fmt_err), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [1:0]  typ;
      logic        has_data;
      logic [3:0]  st, sub, msg;
      logic [63:0] d;
      logic        dv;
      logic [15:0] bus;
      logic        err;
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic v, input logic [3:0] n, input logic dv,
                          input logic [15:0] bus, input logic err, input logic ovf);
      chk({name, ".msg_valid"}, 64'(o_msg_valid), 64'(v));
      chk({name, ".msg_no"}, 64'(o_msg_no), 64'(n));
      chk({name, ".data_valid"}, 64'(o_data_valid), 64'(dv));
      chk({name, ".data_bus"}, 64'(o_data_bus), 64'(bus));
      chk({name, ".fmt_err"}, 64'(o_fmt_err), 64'(err));
      chk({name, ".overflow"}, 64'(o_overflow), 64'(ovf));
   endtask

   task automatic drive(input logic e, input logic [1:0] t, input logic hd, input logic [3:0] s,
                        input logic [3:0] ss, input logic [3:0] m, input logic [63:0] data);
      en = e; typ = t; has_data = hd; st = s; sub = ss; msg = m; d = data; msg_valid = 1'b1;
   endtask

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd2, 64'h0000_0000_0000_05A3, 1'b1, 16'h05A3, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd2, 64'h0000_0000_0000_0800, 1'b1, 16'h0000, 1'b1};
      vecs[2]  = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd4, 4'd6, 64'h0000_0000_0000_1234, 1'b1, 16'h1234, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd4, 4'd6, 64'h0000_0001_0000_1234, 1'b1, 16'h1234, 1'b1};
      vecs[4]  = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd4, 4'd5, 64'h0000_0000_0000_00AB, 1'b0, 16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 2'd0, 1'b0, 4'd5, 4'd0, 4'd3, 64'hDEAD_BEEF_0000_0001, 1'b0, 16'h0000, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 1'b1, 4'd0, 4'd0, 4'd1, 64'h0FFF_F800_0000_00C0, 1'b1, 16'h0016, 1'b0};
      vecs[7]  = '{1'b1, 2'd0, 1'b1, 4'd0, 4'd0, 4'd1, 64'h0FFB_F800_0000_00C0, 1'b1, 16'h0016, 1'b1};
      vecs[8]  = '{1'b1, 2'd1, 1'b1, 4'd0, 4'd0, 4'd1, 64'h0FFF_F800_0010_00C0, 1'b1, 16'h0016, 1'b1};
      vecs[9]  = '{1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 4'd9, 64'h0000_0001_0000_BEEF, 1'b1, 16'hBEEF, 1'b1};
      vecs[10] = '{1'b1, 2'd0, 1'b1, 4'd3, 4'd0, 4'd6, 64'h0000_0000_0000_5555, 1'b1, 16'h5555, 1'b0};
      vecs[11] = '{1'b1, 2'd2, 1'b1, 4'd0, 4'd0, 4'd6, 64'h0000_0000_0000_AAAA, 1'b1, 16'hAAAA, 1'b0};
      vecs[12] = '{1'b1, 2'd1, 1'b1, 4'd0, 4'd0, 4'd6, 64'h0000_0000_0000_0007, 1'b0, 16'h0000, 1'b1};
      vecs[13] = '{1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 4'd6, 64'h0000_0000_0000_0000, 1'b0, 16'h0000, 1'b0};
      vecs[14] = '{1'b1, 2'd0, 1'b0, 4'd3, 4'd0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 16'h0000, 1'b0};
      vecs[15] = '{1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd1, 64'h0000_0000_0000_FFFF, 1'b1, 16'h07FF, 1'b1};

      // reset, with an accept presented during reset that must be discarded
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd2, 64'h5A3);
      tick; tick;
      chk_all("reset", 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0);
      msg_valid = 1'b0; rst = 1'b0;
      tick;
      chk_all("post_reset_idle", 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0);

      // msg_no 0 pulse in IDLE is ignored
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd0, 64'h123);
      tick; msg_valid = 1'b0;
      chk_all("msg0_idle", 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].en, vecs[i].typ, vecs[i].has_data, vecs[i].st, vecs[i].sub, vecs[i].msg, vecs[i].d);
         rdy = 1'b0;
         tick;
         msg_valid = 1'b0;
         chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].msg, vecs[i].dv, vecs[i].bus, vecs[i].err, 1'b0);
         rdy = 1'b1;
         tick;
         rdy = 1'b0;
         chk($sformatf("vec%0d.release", i), 64'(o_msg_valid), 64'd0);
         chk($sformatf("vec%0d.release_dv", i), 64'(o_data_valid), 64'd0);
         chk($sformatf("vec%0d.release_err", i), 64'(o_fmt_err), 64'd0);
      end

      // hold stability: inputs change while held, nothing must move
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd2, 64'h5A3);
      tick;
      msg_valid = 1'b0; en = 1'b1; st = 4'd7; d = 64'hFFFF_FFFF_FFFF_FFFF; msg = 4'd9;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk_all($sformatf("hold%0d", k), 1'b1, 4'd2, 1'b1, 16'h05A3, 1'b0, 1'b0);
      end

      // msg_no 0 while held and not ready: no overflow
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd0, 4'd0, 64'h0);
      tick; msg_valid = 1'b0;
      chk_all("msg0_hold", 1'b1, 4'd2, 1'b1, 16'h05A3, 1'b0, 1'b0);

      // second accept while not ready is dropped and sets sticky overflow
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd4, 4'd6, 64'h1111);
      tick; msg_valid = 1'b0;
      chk_all("drop", 1'b1, 4'd2, 1'b1, 16'h05A3, 1'b0, 1'b1);

      // ready plus accept in the same cycle loads the new message back-to-back
      drive(1'b0, 2'd0, 1'b1, 4'd3, 4'd4, 4'd6, 64'h2222);
      rdy = 1'b1;
      tick; msg_valid = 1'b0; rdy = 1'b0;
      chk_all("b2b", 1'b1, 4'd6, 1'b1, 16'h2222, 1'b0, 1'b1);

      rdy = 1'b1;
      tick; rdy = 1'b0;
      chk("release_keeps_ovf.valid", 64'(o_msg_valid), 64'd0);
      chk("release_keeps_ovf.ovf", 64'(o_overflow), 64'd1);

      // reset mid-HOLD clears everything including overflow
      drive(1'b1, 2'd3, 1'b1, 4'd0, 4'd0, 4'd9, 64'h1_0000_BEEF);
      tick; msg_valid = 1'b0;
      chk_all("pre_rst_hold", 1'b1, 4'd9, 1'b1, 16'hBEEF, 1'b1, 1'b1);
      rst = 1'b1;
      tick; rst = 1'b0;
      chk_all("rst_mid_hold", 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sb_data_decoder.md
SB_DATA_DECODER -- requirements
Module: sb_data_decoder

Interface
REQ-001 SHALL have ports (one per line: name  direction  width  meaning):
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_msg_valid  in  1  deframed sideband message present, one-cycle pulse
- i_has_data  in  1  header indicates a 64-bit data field is present
- i_state  in  4  LTSM state (MBINIT=3)
- i_sub_state  in  4  sub-state (PARAM=0, REVERSALMB=4)
- i_msg_no  in  4  message number (0 = none)
- i_data_field  in  64  received data field
- i_tx_point_sweep_test_en  in  1  point-test/eye-sweep mode
- i_tx_point_sweep_test  in  2  test type: 0 TX_POINT, 1 TX_EYE, 2 RX_POINT, 3 RX_EYE
- i_rdy  in  1  consumer accepts the held output
- o_msg_valid  out  1  decoded message held
- o_msg_no  out  4  message number of the held message
- o_data_valid  out  1  o_data_bus carries payload
- o_data_bus  out  16  extracted payload
- o_fmt_err  out  1  fixed-field mismatch in the held message
- o_overflow  out  1  sticky, a message was dropped
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL implement FSM states IDLE and HOLD; accept = i_msg_valid && i_msg_no!=0.
REQ-004 IDLE: on accept, SHALL register decoded outputs, set o_msg_valid=1 and enter HOLD next cycle (latency 1); otherwise stay in IDLE.
REQ-005 HOLD: SHALL keep all outputs stable while i_rdy=0.
REQ-006 HOLD with i_rdy=1 and no accept: SHALL go to IDLE with o_msg_valid=0, o_data_valid=0, o_fmt_err=0.
REQ-007 HOLD with i_rdy=1 and accept in the same cycle: SHALL load the new message and stay in HOLD (back-to-back, no bubble).
REQ-008 HOLD with i_rdy=0 and accept: SHALL drop the new message, keep the held one and set o_overflow=1 until reset.
REQ-009 msg_no=0 or i_msg_valid=0: SHALL be ignored in every state.
REQ-010 Test mode (en=1, i_has_data=1), msg_no=1: o_data_bus={11'b0,d[59],d[11],d[7:6],d[0]}, o_data_valid=1; o_fmt_err=1 if d[58:43]!=16'hFFFF or any other bit outside {59,11,7,6,0} is 1.
REQ-011 Test mode, msg_no!=1: type 0 or 2 with msg_no=6, or type 3 with msg_no=9 -> o_data_bus=d[15:0], o_data_valid=1, o_fmt_err=(d[63:16]!=0); all other cases -> o_data_valid=0, o_data_bus=0, o_fmt_err=(d!=0).
REQ-012 Normal mode, i_has_data=1: state MBINIT/PARAM -> o_data_bus={5'b0,d[10:0]}, o_fmt_err=(d[63:11]!=0); MBINIT/REVERSALMB with msg_no=6 -> o_data_bus=d[15:0], o_fmt_err=(d[63:16]!=0); o_data_valid=1 in both cases.
REQ-013 Any other state/sub-state/msg_no with data, or i_has_data=0: o_msg_valid=1, o_data_valid=0, o_data_bus=0, o_fmt_err=0.
REQ-014 o_msg_no SHALL equal the i_msg_no of the held message.
REQ-015 Mode and state inputs SHALL be sampled only in the accept cycle.

Reset
REQ-016 i_rst=1 SHALL, at the next edge, force IDLE and set all outputs to 0, including o_overflow, discarding any held message.
REQ-017 An accept in the same cycle as i_rst=1 SHALL be discarded.

Verification
REQ-018 MBINIT/PARAM, msg 2, d=64'h0000_0000_0000_05A3 -> next cycle o_data_bus=16'h05A3, o_data_valid=1, o_fmt_err=0; held until i_rdy=1.
REQ-019 Test en, msg 1, d = encoder image of payload 5'b10110 -> o_data_bus=16'h0016; corrupt bit 50 -> o_fmt_err=1.
REQ-020 RX_EYE msg 9, d=64'h1_0000_BEEF -> o_data_bus=16'hBEEF, o_fmt_err=1.
REQ-021 HOLD with i_rdy=0, second accept -> first message retained, o_overflow=1; with i_rdy=1 and accept in the same cycle -> second message loaded, o_msg_valid stays 1.
REQ-022 Accept with i_has_data=0 (state ACTIVE) -> o_msg_valid=1, o_data_valid=0; i_rst mid-HOLD -> all outputs 0 next cycle.
REQ-023 msg_no=0 pulse -> no output change.
